// File: rtl/register_bank_shift_if.sv
// Bus bundle for register_bank_shift: operation controls, read select and status.
// The parity signals exist only when REGISTER_BANK_PARITY_EN is defined.
interface register_bank_shift_if #(
    parameter int NrOfBits = 8,
    parameter int AddrBits = 2,
    parameter int CntBits  = 3
);
    logic                ClockEnable;
    logic                Tick;
    logic                pre;
    logic [1:0]          Op;
    logic [AddrBits-1:0] WrAddr;
    logic [NrOfBits-1:0] D;
    logic [AddrBits-1:0] RdAddr;
    logic                cs;
    logic                QValid;
    logic [CntBits-1:0]  ValidCount;
    logic                Full;
    logic                Empty;
`ifdef REGISTER_BANK_PARITY_EN
    logic                InjErr;
    logic                ParErr;

    modport master (
        output ClockEnable, Tick, pre, Op, WrAddr, D, RdAddr, cs, InjErr,
        input  QValid, ValidCount, Full, Empty, ParErr
    );

    modport slave (
        input  ClockEnable, Tick, pre, Op, WrAddr, D, RdAddr, cs, InjErr,
        output QValid, ValidCount, Full, Empty, ParErr
    );
`else
    modport master (
        output ClockEnable, Tick, pre, Op, WrAddr, D, RdAddr, cs,
        input  QValid, ValidCount, Full, Empty
    );

    modport slave (
        input  ClockEnable, Tick, pre, Op, WrAddr, D, RdAddr, cs,
        output QValid, ValidCount, Full, Empty
    );
`endif
endinterface

// File: rtl/register_bank_shift.sv
// Depth x NrOfBits register bank with per-entry valid bits, addressed write, shift insert,
// invalidate, preset and a registered tri-state read port. Optional macro: REGISTER_BANK_PARITY_EN.
module register_bank_shift #(
    parameter int NrOfBits = 8,
    parameter int Depth    = 4,
    parameter int AddrBits = 2,
    parameter int CntBits  = 3
) (
    input  logic                     Clock,
    input  logic                     Reset,
    register_bank_shift_if.slave     bus,
    output wire  [NrOfBits-1:0]      Q
);

    localparam logic [1:0]         OP_HOLD  = 2'b00;
    localparam logic [1:0]         OP_WRITE = 2'b01;
    localparam logic [1:0]         OP_SHIFT = 2'b10;
    localparam logic [1:0]         OP_INVAL = 2'b11;
    localparam logic [CntBits-1:0] DEPTH_C  = CntBits'(Depth);

    logic [NrOfBits-1:0] entry_q [Depth];
    logic [NrOfBits-1:0] entry_d [Depth];
    logic [Depth-1:0]    valid_q;
    logic [Depth-1:0]    valid_d;
    logic [NrOfBits-1:0] q_q;
    logic [NrOfBits-1:0] q_d;
    logic                qvalid_q;
    logic                qvalid_d;
    logic [CntBits-1:0]  cnt_q;
    logic [CntBits-1:0]  cnt_d;
    logic                full_q;
    logic                full_d;
    logic                empty_q;
    logic                empty_d;
    logic                en_s;

`ifdef REGISTER_BANK_PARITY_EN
    logic [Depth-1:0]    par_q;
    logic [Depth-1:0]    par_d;
    logic                parerr_q;
    logic                parerr_d;
`endif

    function automatic logic [CntBits-1:0] popcount(input logic [Depth-1:0] v);
        logic [CntBits-1:0] c;
        c = {CntBits{1'b0}};
        for (int i = 0; i < Depth; i++) begin
            c = c + {{(CntBits-1){1'b0}}, v[i]};
        end
        return c;
    endfunction

    function automatic logic even_parity(input logic [NrOfBits-1:0] data);
        return ^data;
    endfunction

    assign en_s = bus.ClockEnable & bus.Tick;

    // Next-state of the bank: preset wins over the gated operation.
    always_comb begin
        entry_d = entry_q;
        valid_d = valid_q;
`ifdef REGISTER_BANK_PARITY_EN
        par_d   = par_q;
`endif
        if (bus.pre) begin
            for (int i = 0; i < Depth; i++) begin
                entry_d[i] = {NrOfBits{1'b1}};
`ifdef REGISTER_BANK_PARITY_EN
                par_d[i]   = even_parity({NrOfBits{1'b1}});
`endif
            end
            valid_d = {Depth{1'b1}};
        end else if (en_s) begin
            case (bus.Op)
                OP_WRITE: begin
                    // Out-of-range addresses match no entry, so the write drops.
                    for (int i = 0; i < Depth; i++) begin
                        if (bus.WrAddr == AddrBits'(i)) begin
                            entry_d[i] = bus.D;
                            valid_d[i] = 1'b1;
`ifdef REGISTER_BANK_PARITY_EN
                            par_d[i]   = even_parity(bus.D) ^ bus.InjErr;
`endif
                        end else begin
                            entry_d[i] = entry_d[i];
                        end
                    end
                end
                OP_SHIFT: begin
                    for (int i = Depth - 1; i > 0; i--) begin
                        entry_d[i] = entry_q[i-1];
                        valid_d[i] = valid_q[i-1];
`ifdef REGISTER_BANK_PARITY_EN
                        par_d[i]   = par_q[i-1];
`endif
                    end
                    entry_d[0] = bus.D;
                    valid_d[0] = 1'b1;
`ifdef REGISTER_BANK_PARITY_EN
                    par_d[0]   = even_parity(bus.D);
`endif
                end
                OP_INVAL: begin
                    for (int i = 0; i < Depth; i++) begin
                        if (bus.WrAddr == AddrBits'(i)) begin
                            valid_d[i] = 1'b0;
                        end else begin
                            valid_d[i] = valid_d[i];
                        end
                    end
                end
                OP_HOLD: begin
                    valid_d = valid_q;
                end
                default: begin
                    valid_d = valid_q;
                end
            endcase
        end else begin
            valid_d = valid_q;
        end
    end

    // Read port and status: read samples pre-update contents, status reflects post-update.
    always_comb begin
        q_d      = {NrOfBits{1'b0}};
        qvalid_d = 1'b0;
`ifdef REGISTER_BANK_PARITY_EN
        parerr_d = 1'b0;
`endif
        for (int i = 0; i < Depth; i++) begin
            if (bus.RdAddr == AddrBits'(i)) begin
                q_d      = entry_q[i];
                qvalid_d = valid_q[i];
`ifdef REGISTER_BANK_PARITY_EN
                parerr_d = par_q[i] ^ even_parity(entry_q[i]);
`endif
            end else begin
                q_d = q_d;
            end
        end
        cnt_d   = popcount(valid_d);
        full_d  = (cnt_d == DEPTH_C);
        empty_d = (cnt_d == {CntBits{1'b0}});
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge Clock) begin
        if (Reset) begin
            for (int i = 0; i < Depth; i++) begin
                entry_q[i] <= {NrOfBits{1'b0}};
            end
            valid_q  <= {Depth{1'b0}};
            q_q      <= {NrOfBits{1'b0}};
            qvalid_q <= 1'b0;
            cnt_q    <= {CntBits{1'b0}};
            full_q   <= 1'b0;
            empty_q  <= 1'b1;
`ifdef REGISTER_BANK_PARITY_EN
            par_q    <= {Depth{1'b0}};
            parerr_q <= 1'b0;
`endif
        end else begin
            for (int i = 0; i < Depth; i++) begin
                entry_q[i] <= entry_d[i];
            end
            valid_q  <= valid_d;
            q_q      <= q_d;
            qvalid_q <= qvalid_d;
            cnt_q    <= cnt_d;
            full_q   <= full_d;
            empty_q  <= empty_d;
`ifdef REGISTER_BANK_PARITY_EN
            par_q    <= par_d;
            parerr_q <= parerr_d;
`endif
        end
    end

    assign Q              = bus.cs ? {NrOfBits{1'bz}} : q_q;
    assign bus.QValid     = qvalid_q;
    assign bus.ValidCount = cnt_q;
    assign bus.Full       = full_q;
    assign bus.Empty      = empty_q;
`ifdef REGISTER_BANK_PARITY_EN
    assign bus.ParErr     = parerr_q;
`endif

endmodule

// File: tb/tb_register_bank_shift.sv
// Scoreboard bench for register_bank_shift (8 x 4): directed plan followed by random traffic.
module tb_register_bank_shift;

    typedef struct {
        logic [7:0] q;
        logic       qv;
        logic [2:0] cnt;
        logic       full;
        logic       empty;
        logic       cs;
    } exp_t;

    logic       clk;
    logic       rst;
    wire  [7:0] q;
    int         tests;
    int         fails;
    exp_t       sb[$];
    logic [7:0] m_data[$];
    logic       m_valid[$];

    register_bank_shift_if #(.NrOfBits(8), .AddrBits(2), .CntBits(3)) bus ();

    register_bank_shift #(.NrOfBits(8), .Depth(4), .AddrBits(2), .CntBits(3)) dut (
        .Clock (clk),
        .Reset (rst),
        .bus   (bus),
        .Q     (q)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic model_clear();
        m_data.delete();
        m_valid.delete();
        for (int i = 0; i < 4; i++) begin
            m_data.push_back(8'h00);
            m_valid.push_back(1'b0);
        end
    endtask

    // One clock of stimulus; the expected outputs after the following edge go to the scoreboard.
    task automatic step(input bit r, input bit p, input bit ce, input bit tk, input logic [1:0] op,
                        input logic [1:0] wa, input logic [7:0] d, input logic [1:0] ra, input bit c);
        exp_t e;
        int   n;
        @(negedge clk);
        rst = r; bus.pre = p; bus.ClockEnable = ce; bus.Tick = tk; bus.Op = op;
        bus.WrAddr = wa; bus.D = d; bus.RdAddr = ra; bus.cs = c;
        e.cs = c;
        if (r) begin
            e.q = 8'h00; e.qv = 1'b0;
            model_clear();
        end else begin
            e.q  = m_data[ra];
            e.qv = m_valid[ra];
            if (p) begin
                for (int i = 0; i < 4; i++) begin
                    m_data[i] = 8'hFF; m_valid[i] = 1'b1;
                end
            end else if (ce && tk) begin
                if (op == 2'b01) begin
                    m_data[wa] = d; m_valid[wa] = 1'b1;
                end else if (op == 2'b10) begin
                    m_data.push_front(d);   void'(m_data.pop_back());
                    m_valid.push_front(1'b1); void'(m_valid.pop_back());
                end else if (op == 2'b11) begin
                    m_valid[wa] = 1'b0;
                end
            end
        end
        n = 0;
        for (int i = 0; i < 4; i++) n += int'(m_valid[i]);
        e.cnt = 3'(n); e.full = (n == 4); e.empty = (n == 0);
        sb.push_back(e);
    endtask

    task automatic rd(input logic [1:0] ra);
        step(0, 0, 1, 1, 2'b00, 2'd0, 8'h00, ra, 0);
    endtask

    // Monitor: after every edge, compare the DUT outputs against the oldest expectation.
    always @(posedge clk) begin
        exp_t e;
        #2;
        if (sb.size() > 0) begin
            e = sb.pop_front();
            if (e.cs) begin
                tests++;
                // A 2-state simulator resolves the undriven bus to zero.
                if (!((q === 8'bzzzz_zzzz) || (q === 8'h00))) begin
                    fails++;
                    $display("FAIL q_hiz: got %0h expected zz", q);
                end
            end else begin
                chk("q", 32'(q), 32'(e.q));
            end
            chk("qvalid", 32'(bus.QValid), 32'(e.qv));
            chk("count", 32'(bus.ValidCount), 32'(e.cnt));
            chk("full", 32'(bus.Full), 32'(e.full));
            chk("empty", 32'(bus.Empty), 32'(e.empty));
        end
    end

    initial begin
        tests = 0; fails = 0;
        rst = 1'b1; bus.pre = 1'b0; bus.ClockEnable = 1'b0; bus.Tick = 1'b0; bus.Op = 2'b00;
        bus.WrAddr = 2'd0; bus.D = 8'h00; bus.RdAddr = 2'd0; bus.cs = 1'b0;
        model_clear();

        // 1: reset then read every entry
        step(1, 0, 0, 0, 2'b00, 2'd0, 8'h00, 2'd0, 0);
        for (int i = 0; i < 4; i++) rd(2'(i));
        // 2: fill by addressed writes, read entry 2
        step(0, 0, 1, 1, 2'b01, 2'd0, 8'h11, 2'd0, 0);
        step(0, 0, 1, 1, 2'b01, 2'd1, 8'h22, 2'd0, 0);
        step(0, 0, 1, 1, 2'b01, 2'd2, 8'h33, 2'd0, 0);
        step(0, 0, 1, 1, 2'b01, 2'd3, 8'h44, 2'd0, 0);
        rd(2'd2); rd(2'd2);
        // 3: gated write ignored, then read-before-write on entry 1
        step(0, 0, 1, 0, 2'b01, 2'd1, 8'hAA, 2'd1, 0);
        step(0, 0, 1, 1, 2'b01, 2'd1, 8'h5A, 2'd1, 0);
        rd(2'd1); rd(2'd1);
        // 4: shift five values from empty
        step(1, 0, 0, 0, 2'b00, 2'd0, 8'h00, 2'd0, 0);
        step(0, 0, 1, 1, 2'b10, 2'd0, 8'hA1, 2'd0, 0);
        step(0, 0, 1, 1, 2'b10, 2'd0, 8'hB2, 2'd0, 0);
        step(0, 0, 1, 1, 2'b10, 2'd0, 8'hC3, 2'd0, 0);
        step(0, 0, 1, 1, 2'b10, 2'd0, 8'hD4, 2'd0, 0);
        step(0, 0, 1, 1, 2'b10, 2'd0, 8'hE5, 2'd0, 0);
        for (int i = 0; i < 4; i++) rd(2'(i));
        rd(2'd0);
        // 5: preset beats a write, then invalidate entry 3
        step(0, 1, 1, 1, 2'b01, 2'd2, 8'h00, 2'd0, 0);
        step(0, 0, 1, 1, 2'b11, 2'd3, 8'h00, 2'd3, 0);
        rd(2'd3); rd(2'd3);
        // 6: output disable, then reset in the middle of shifting
        step(0, 0, 1, 1, 2'b00, 2'd0, 8'h00, 2'd0, 1);
        step(0, 0, 1, 1, 2'b00, 2'd0, 8'h00, 2'd0, 1);
        step(0, 0, 1, 1, 2'b10, 2'd0, 8'h01, 2'd0, 0);
        step(1, 0, 1, 1, 2'b10, 2'd0, 8'h02, 2'd0, 0);
        step(0, 0, 1, 1, 2'b10, 2'd0, 8'h03, 2'd0, 0);
        rd(2'd0);

        // Random traffic
        for (int k = 0; k < 400; k++) begin
            step(($urandom_range(39) == 0), ($urandom_range(29) == 0), ($urandom_range(7) != 0),
                 ($urandom_range(5) != 0), 2'($urandom_range(3)), 2'($urandom_range(3)),
                 8'($urandom_range(255)), 2'($urandom_range(3)), ($urandom_range(7) == 0));
        end

        repeat (3) @(negedge clk);
        chk("drain", 32'(sb.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
